mult_share_arb: RTL
===================

# mult_share_arb

Round-robin arbiter and sequencer that shares one 3-bit × 4-bit unsigned product datapath (7-bit result) between two independent requesters. Each requester has a valid/ready request channel carrying operands and a valid/ready response channel returning its own result. The block sits between client logic and the product unit: it serialises access, holds operands and result stable in registers, and routes each result back only to the requester that issued it.

## Interface

Parameters:
- RR_INIT, default 0: requester (0 or 1) given priority on the first arbitration after reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has operands
- req0_a  input  3  requester 0 multiplier operand
- req0_b  input  4  requester 0 multiplicand operand
- req0_ready  output  1  request 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0
- rsp0_valid  output  1  result for requester 0 available
- rsp0_res  output  7  result for requester 0
- rsp0_ready  input  1  requester 0 consumes result
- rsp1_valid, rsp1_res, rsp1_ready: same as requester 0
- busy  output  1  high whenever state is not IDLE

## Operation

- FSM states: IDLE, CALC, RESP.
- IDLE: grant is decided combinationally from req0_valid/req1_valid and the priority pointer. Only one valid -> grant it. Both valid -> grant the pointer's requester. reqN_ready = (state==IDLE) & grantN, so ready can depend on valid. Handshake (valid & ready) latches a_reg, b_reg and owner_id, then goes to CALC. Neither valid -> stay in IDLE.
- CALC: exactly one cycle. res_reg <= a_reg × b_reg, unsigned and zero-extended to 7 bits. The maximum is 7×15 = 105, so there is no overflow. Next state is RESP.
- RESP: rsp{owner}_valid = 1 and rsp{owner}_res = res_reg, both held stable until rsp{owner}_ready = 1. The other response channel keeps valid = 0 and res = 0. When the handshake completes: return to IDLE and set the pointer to the requester that was not owner.
- Non-owner rsp ready is ignored. req*_ready stays 0 outside IDLE, and requests presented then stay pending.
- rspN_res is 0 whenever rspN_valid = 0.
- Reset, asynchronous at any time including mid-transaction:
  - state = IDLE, the in-flight transaction is discarded and no response is produced
  - all outputs 0; a_reg, b_reg and res_reg = 0
  - pointer = RR_INIT

## Timing

- Request accepted at edge T (handshake cycle T-1 -> T). State is CALC during cycle T, and rsp_valid is high from cycle T+1, i.e. the second cycle after the handshake cycle.
- Response handshake in cycle R -> IDLE at R+1. The next request can be accepted in cycle R+1.
- Minimum period is 3 cycles per operation: accept, CALC, RESP with ready already high.
- A response can be held indefinitely. Backpressure stalls both requesters.
- Starvation bound: with both requesters continuously valid, grants strictly alternate 0,1,0,1…

## Test plan

- Reset values: assert rst asynchronously mid-cycle -> all outputs 0 immediately, and busy = 0.
- Single request, RR_INIT = 0: req0 a=5, b=11, rsp0_ready=1 -> req0_ready in the accept cycle, rsp0_valid with rsp0_res=55 two cycles later, and rsp1_valid stays 0.
- Exhaustive products: all 128 (a,b) pairs on requester 1 -> each result equals a×b; check extremes 0×0=0 and 7×15=105.
- Contention: both valid continuously, req0 (3,4) and req1 (6,9) -> results in the order 12 (rsp0), 54 (rsp1), 12, 54…, with a 3-cycle period when rsp ready is tied high.
- Backpressure: rsp1_ready=0 for 10 cycles after rsp1_valid rises, with req0 valid during that time -> rsp1_res stable, req0_ready=0 throughout, and req0 accepted the cycle after the rsp1 handshake.
- Reset mid-operation: rst pulse during CALC of req0 (2,3) -> no rsp0_valid afterwards. The next arbitration with both valid grants requester RR_INIT.

Source files
------------

// File: rtl/mult_share_arb.sv
// mult_share_arb: round-robin arbiter that shares one 3x4-bit unsigned
// product unit between two requesters. Each requester owns a valid/ready
// request channel (operands in) and a valid/ready response channel (result
// out). One operation is in flight at a time; its result returns only to
// the requester that issued it.
//
// Handshake rules (all four channels): a transfer happens on a rising edge
// when valid and ready are both high in the cycle before it. The request
// side's ready may depend on valid, because the grant is decided from the
// valids in IDLE. A response's valid and data are held stable until the
// owner raises ready. A request seen while busy simply waits; nothing is
// dropped.
module mult_share_arb #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [6:0] rsp0_res,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  output logic [6:0] rsp1_res,
  input  logic       rsp1_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic PTR_INIT = (RR_INIT != 0);

  state_t     state;
  state_t     state_next;

  // ptr names the requester that wins when both are valid in IDLE
  logic       ptr;
  logic       owner;
  logic [2:0] a_reg;
  logic [3:0] b_reg;
  logic [6:0] res_reg;

  logic       grant0;
  logic       grant1;
  logic       req_hs;
  logic       rsp_hs;
  logic [6:0] product;

  // Grant: a lone valid always wins; with both valid the pointer decides
  always_comb begin
    grant0 = req0_valid & (~req1_valid | (ptr == 1'b0));
    grant1 = req1_valid & (~req0_valid | (ptr == 1'b1));
  end

  // Handshake strobes for the request side and the owner's response side
  always_comb begin
    req_hs = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    rsp_hs = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
  end

  // Zero-extended unsigned product; 7*15 = 105 fits in 7 bits
  always_comb begin
    product = {4'b0000, a_reg} * {3'b000, b_reg};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: accept -> one compute cycle -> hold result until taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_hs) begin
          state_next = CALC;
        end
      end
      CALC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs: ready only in IDLE (forced low while reset is applied),
  // response valid/data only toward the owner, zero otherwise
  always_comb begin
    busy       = (state != IDLE);
    req0_ready = ~rst & (state == IDLE) & grant0;
    req1_ready = ~rst & (state == IDLE) & grant1;
    rsp0_valid = (state == RESP) & (owner == 1'b0);
    rsp1_valid = (state == RESP) & (owner == 1'b1);
    rsp0_res   = rsp0_valid ? res_reg : 7'd0;
    rsp1_res   = rsp1_valid ? res_reg : 7'd0;
  end

  // Operand capture, product register and round-robin pointer update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= 3'd0;
      b_reg   <= 4'd0;
      res_reg <= 7'd0;
      owner   <= 1'b0;
      ptr     <= PTR_INIT;
    end else begin
      if (state == IDLE && req_hs) begin
        owner <= grant1;
        a_reg <= grant1 ? req1_a : req0_a;
        b_reg <= grant1 ? req1_b : req0_b;
      end
      if (state == CALC) begin
        res_reg <= product;
      end
      if (state == RESP && rsp_hs) begin
        ptr <= ~owner;
      end
    end
  end

endmodule
